// File: rtl/seg7_bcd_display.sv
// Binary-to-BCD (serial double-dabble) converter driving DIGITS active-low 7-segment digits.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module seg7_bcd_display #(
    parameter int IN_W   = 20,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_value,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_ovf,
    output logic [7*DIGITS-1:0]   o_seven
);

    localparam int ACC_W = 4*DIGITS + 4;
    localparam int SR_W  = ACC_W + IN_W;
    localparam int CNT_W = 6;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1011000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = DASH;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [SR_W-1:0]     sr;
    logic [SR_W-1:0]     dab;
    logic [SR_W-1:0]     sr_next;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_pending;
    logic                disp_ovf;
    logic [3:0]          nib;
    logic [7*DIGITS-1:0] seven_next;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                blank_run;
`endif

    // One double-dabble step over every nibble, including the spare top one.
    always_comb begin
        dab = sr;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (dab[IN_W+4*d +: 4] >= 4'd5)
                dab[IN_W+4*d +: 4] = dab[IN_W+4*d +: 4] + 4'd3;
        end
        sr_next = dab << 1;
    end

    // The spare nibble only catches part of an overflow, so the latched compare is authoritative.
    always_comb begin
        disp_ovf   = ovf_pending || (sr[SR_W-1 -: 4] != 4'd0);
        seven_next = '0;
        nib        = 4'd0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_run  = 1'b1;
`endif
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = sr[IN_W+4*k +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (nib != 4'd0 || k == 0) blank_run = 1'b0;
            seven_next[7*k +: 7] = blank_run ? BLANK : seg_of(nib);
`else
            seven_next[7*k +: 7] = seg_of(nib);
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            o_ready     <= 1'b1;
            o_done      <= 1'b0;
            o_ovf       <= 1'b0;
            o_seven     <= {DIGITS{DASH}};
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sr          <= {{ACC_W{1'b0}}, i_value};
                        cnt         <= CNT_W'(IN_W);
                        ovf_pending <= (64'(i_value) >= LIMIT);
                        o_ready     <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: begin
                    o_seven <= disp_ovf ? {DIGITS{DASH}} : seven_next;
                    o_ovf   <= disp_ovf;
                    o_done  <= 1'b1;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Directed self-checking bench for seg7_bcd_display (default build and IN_W=5/DIGITS=2 instance).
module tb_seg7_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] value;
    logic        ready, done, ovf;
    logic [27:0] seven;
    logic        s_start;
    logic [4:0]  s_value;
    logic        s_ready, s_done, s_ovf;
    logic [13:0] s_seven;

    always #5 clk = ~clk;

    seg7_bcd_display dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_value(value),
        .o_ready(ready), .o_done(done), .o_ovf(ovf), .o_seven(seven)
    );

    seg7_bcd_display #(.IN_W(5), .DIGITS(2)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_value(s_value),
        .o_ready(s_ready), .o_done(s_done), .o_ovf(s_ovf), .o_seven(s_seven)
    );

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1011000, S8 = 7'b0000000,
                           S9 = 7'b0010000, D  = 7'b0111111, B  = 7'b1111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int lat;
    int pulses;
    logic        acc_ready;
    logic [27:0] acc_seven;

    // Hand-chosen digits; nz is how many leading digits go blank when blanking is built in.
    function automatic logic [27:0] lz(input logic [6:0] d3, d2, d1, d0, input int nz);
        logic [6:0] d [4];
        d = '{d0, d1, d2, d3};
        if (BLANK_EN)
            for (int k = 3; k > 3 - nz; k--) d[k] = B;
        return {d[3], d[2], d[1], d[0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept v on the next edge, then count edges until o_done is seen (bounded).
    task automatic applyStimulus(input logic [19:0] v, output int latency);
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        acc_ready = ready;
        acc_seven = seven;
        latency   = 0;
        do begin
            @(posedge clk);
            #1;
            latency++;
        end while (!done && latency < 200);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        value   = '0;
        s_start = 1'b0;
        s_value = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 28'(ready), 28'd1);
        checkOutput("rst_done",  28'(done),  28'd0);
        checkOutput("rst_ovf",   28'(ovf),   28'd0);
        checkOutput("rst_seven", seven, {D, D, D, D});
        rst_n = 1'b1;

        applyStimulus(20'd1234, lat);
        checkOutput("1234_lat",       28'(lat), 28'd21);
        checkOutput("1234_acc_ready", 28'(acc_ready), 28'd0);
        checkOutput("1234_acc_seven", acc_seven, {D, D, D, D});
        checkOutput("1234_seven",     seven, {S1, S2, S3, S4});
        checkOutput("1234_ovf",       28'(ovf), 28'd0);
        @(posedge clk);
        #1;
        checkOutput("1234_done_fall", 28'(done),  28'd0);
        checkOutput("1234_ready",     28'(ready), 28'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("1234_hold",      seven, {S1, S2, S3, S4});

        applyStimulus(20'd9999, lat);
        checkOutput("9999_seven", seven, {S9, S9, S9, S9});
        checkOutput("9999_ovf",   28'(ovf), 28'd0);

        @(negedge clk);
        value = 20'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 20'd77;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("42_pulses", 28'(pulses), 28'd1);
        checkOutput("42_seven",  seven, lz(S0, S0, S4, S2, 2));

        applyStimulus(20'd0, lat);
        checkOutput("0_seven", seven, lz(S0, S0, S0, S0, 3));

        applyStimulus(20'd10000, lat);
        checkOutput("10000_lat",   28'(lat), 28'd21);
        checkOutput("10000_seven", seven, {D, D, D, D});
        checkOutput("10000_ovf",   28'(ovf), 28'd1);

        @(negedge clk);
        value = 20'd5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_seven", seven, {D, D, D, D});
        checkOutput("midrst_ready", 28'(ready), 28'd1);
        checkOutput("midrst_done",  28'(done),  28'd0);
        checkOutput("midrst_ovf",   28'(ovf),   28'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", 28'(pulses), 28'd0);
        checkOutput("midrst_hold",    seven, {D, D, D, D});

        checkOutput("7_ready_before", 28'(ready), 28'd1);
        applyStimulus(20'd7, lat);
        checkOutput("7_lat",   28'(lat), 28'd21);
        checkOutput("7_seven", seven, lz(S0, S0, S0, S7, 3));

        @(negedge clk);
        s_value = 5'd31;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!s_done && lat < 200);
        checkOutput("small_lat",   28'(lat), 28'd6);
        checkOutput("small_seven", 28'(s_seven), 28'({S3, S1}));
        checkOutput("small_ovf",   28'(s_ovf), 28'd0);
        checkOutput("small_ready", 28'(s_ready), 28'd1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
